md_sequencer: RTL
=================

Name: md_sequencer

Overview:
- Upstream issue/writeback stage for the iterative multiplier and divider units in the execute path.
- Latches operands and destination register from the execute stage, pulses start to the selected unit, and holds the pipeline stall while the unit iterates.
- Captures result/exception on ready and presents one writeback beat to the register-file write port.
- Converts unit exceptions into a status-register write (rstatus = r30).

Parameters:
- DATA_W, 32, operand/result width
- TIMEOUT, 40, max cycles in WAIT before forced abort (divider needs 33)
- MUL_EXC_CODE, 4, rstatus value on multiply overflow
- DIV_EXC_CODE, 5, rstatus value on divide-by-zero
- STATUS_REG, 30, register index written on exception

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- issue_mult  in  1  execute stage has a MUL this cycle
- issue_div  in  1  execute stage has a DIV this cycle
- op_a  in  DATA_W  operand A (dividend/multiplicand)
- op_b  in  DATA_W  operand B (divisor/multiplier)
- dest_in  in  5  destination register of issuing instruction
- flush  in  1  pipeline flush; cancels in-flight op
- md_ready  in  1  selected unit finished
- md_result  in  DATA_W  selected unit result
- md_exception  in  1  selected unit exception (overflow / divide-by-zero)
- start_mult  out  1  one-cycle start to multiplier
- start_div  out  1  one-cycle start to divider
- md_a  out  DATA_W  latched operand A, stable LAUNCH..WB
- md_b  out  DATA_W  latched operand B, stable LAUNCH..WB
- md_interrupt  out  1  abort to unit (flush or timeout)
- stall  out  1  freeze fetch/decode/execute
- wb_valid  out  1  writeback beat valid
- wb_reg  out  5  writeback register index
- wb_data  out  DATA_W  writeback data

Behaviour:
- Reset (async, active-high): state IDLE; all outputs 0; counter 0; latches 0.
- States: IDLE, LAUNCH, WAIT, WB.
- IDLE: on issue_mult|issue_div (and no flush), latch op_a, op_b, dest_in, and kind (mult/div) -> LAUNCH. If both issue bits are set, div wins. stall=0 in IDLE.
- LAUNCH (1 cycle): start_mult or start_div = 1 per kind; stall=1; counter cleared -> WAIT.
- WAIT: stall=1; counter increments each cycle.
  - md_ready is ignored on the first WAIT cycle (guard against a stale ready from the prior op).
  - From the second WAIT cycle, md_ready=1 registers md_result/md_exception -> WB.
- WB (1 cycle): wb_valid=1; stall=1 -> IDLE.
  - No exception: wb_reg=dest latch, wb_data=result.
  - Exception: wb_reg=STATUS_REG, wb_data = MUL_EXC_CODE or DIV_EXC_CODE per kind.
- Issue-to-writeback latency: LAUNCH + N unit cycles + WB. Divider (ready after 33 clocks) gives a 35-cycle stall.
- stall deasserts the cycle after WB; a new issue in that IDLE cycle is accepted.
- flush in LAUNCH/WAIT:
  - md_interrupt=1 for one cycle; next state IDLE; no wb_valid.
  - flush in WB: writeback still completes (instruction already committed).
  - flush with issue in IDLE: issue ignored.
- wb_reg=0 without exception: wb_valid still asserted; the register file discards writes to r0.
- Counter saturates at TIMEOUT.

Optional Feature:
- Macro MD_TIMEOUT_EN.
- Defined:
  - When the counter reaches TIMEOUT in WAIT, assert md_interrupt for one cycle and go to WB.
  - The WB beat is forced to the exception path, using the kind's code.
- Undefined:
  - Counter logic is absent; WAIT exits only on md_ready or flush.

Decomposition:
- Shared package md_pkg:
  - state encoding constants (IDLE=0, LAUNCH=1, WAIT=2, WB=3)
  - MUL_EXC_CODE/DIV_EXC_CODE defaults
  - STATUS_REG index
  - kind encoding (MUL=0, DIV=1)
- One sub-module: md_operand_latch, an enable-gated register bank for op_a/op_b/dest/kind built from dffe_ref cells (enable = accept in IDLE).

Test Plan:
- DIV 100 / -7 into dest 3; unit ready after 33 cycles -> start_div pulse once; stall high 35 cycles; wb_valid one cycle, wb_reg=3, wb_data=-14.
- DIV 5 / 0, md_exception=1 at ready -> wb_reg=30, wb_data=5; dest register not written.
- MUL 0x10000 * 0x10000 with overflow -> wb_reg=30, wb_data=4.
- flush on 10th WAIT cycle -> md_interrupt one cycle; IDLE next; no wb_valid; stall low next cycle.
- md_ready held high from the previous op across a new issue -> ignored on first WAIT cycle; capture only a ready from the second WAIT cycle onward.
- MD_TIMEOUT_EN, TIMEOUT=40, ready never asserted -> md_interrupt at counter 40; WB with wb_reg=30, wb_data=DIV_EXC_CODE. Reset asserted mid-WAIT -> all outputs 0 immediately.

Source files
------------

// File: rtl/md_pkg.sv
// Shared encodings and defaults for the multiply/divide issue sequencer.
package md_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_WB     = 2'd3
    } md_state_e;

    typedef enum logic {
        KIND_MUL = 1'b0,
        KIND_DIV = 1'b1
    } md_kind_e;

    localparam int REG_W            = 5;
    localparam int DEF_MUL_EXC_CODE = 4;
    localparam int DEF_DIV_EXC_CODE = 5;
    localparam int DEF_STATUS_REG   = 30;

    // A simultaneous MUL and DIV issue resolves to DIV.
    function automatic md_kind_e issueKind(input logic issueDiv);
        return issueDiv ? KIND_DIV : KIND_MUL;
    endfunction

endpackage

// File: rtl/dffe_ref.sv
// Reference enable-gated flop bank with asynchronous active-high clear.
module dffe_ref #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/md_operand_latch.sv
// Operand/destination/kind holding registers, loaded once per accepted issue.
module md_operand_latch
    import md_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DATA_W-1:0] aIn,
    input  logic [DATA_W-1:0] bIn,
    input  logic [REG_W-1:0]  destIn,
    input  md_kind_e          kindIn,
    output logic [DATA_W-1:0] aOut,
    output logic [DATA_W-1:0] bOut,
    output logic [REG_W-1:0]  destOut,
    output md_kind_e          kindOut
);

    logic kindQ;

    dffe_ref #(.W(DATA_W)) uA (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .d   (aIn),
        .q   (aOut)
    );

    dffe_ref #(.W(DATA_W)) uB (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .d   (bIn),
        .q   (bOut)
    );

    dffe_ref #(.W(REG_W)) uDest (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .d   (destIn),
        .q   (destOut)
    );

    dffe_ref #(.W(1)) uKind (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .d   (kindIn),
        .q   (kindQ)
    );

    assign kindOut = md_kind_e'(kindQ);

endmodule

// File: rtl/md_sequencer.sv
// Issue/writeback sequencer for the iterative multiplier and divider.
// Optional WAIT timeout abort is enabled by defining MD_TIMEOUT_EN.
module md_sequencer
    import md_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int TIMEOUT      = 40,
    parameter int MUL_EXC_CODE = DEF_MUL_EXC_CODE,
    parameter int DIV_EXC_CODE = DEF_DIV_EXC_CODE,
    parameter int STATUS_REG   = DEF_STATUS_REG
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              issue_mult,
    input  logic              issue_div,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    input  logic [REG_W-1:0]  dest_in,
    input  logic              flush,
    input  logic              md_ready,
    input  logic [DATA_W-1:0] md_result,
    input  logic              md_exception,
    output logic              start_mult,
    output logic              start_div,
    output logic [DATA_W-1:0] md_a,
    output logic [DATA_W-1:0] md_b,
    output logic              md_interrupt,
    output logic              stall,
    output logic              wb_valid,
    output logic [REG_W-1:0]  wb_reg,
    output logic [DATA_W-1:0] wb_data
);

    md_state_e         state;
    md_kind_e          kindQ;
    logic [REG_W-1:0]  destQ;
    logic              firstWait;
    logic              accept;
    logic [DATA_W-1:0] excData;

    assign accept  = (state == ST_IDLE) && (issue_mult || issue_div) && !flush;
    assign excData = (kindQ == KIND_DIV) ? DATA_W'(DIV_EXC_CODE) : DATA_W'(MUL_EXC_CODE);

    md_operand_latch #(.DATA_W(DATA_W)) uLatch (
        .clk     (clk),
        .rst     (reset),
        .en      (accept),
        .aIn     (op_a),
        .bIn     (op_b),
        .destIn  (dest_in),
        .kindIn  (issueKind(issue_div)),
        .aOut    (md_a),
        .bOut    (md_b),
        .destOut (destQ),
        .kindOut (kindQ)
    );

`ifdef MD_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] waitCnt;
    logic             timedOut;

    assign timedOut = (waitCnt == CNT_W'(TIMEOUT));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            waitCnt <= '0;
        end else if (state == ST_LAUNCH) begin
            waitCnt <= '0;
        end else if (state == ST_WAIT && !timedOut) begin
            waitCnt <= waitCnt + 1'b1;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            firstWait    <= 1'b0;
            start_mult   <= 1'b0;
            start_div    <= 1'b0;
            md_interrupt <= 1'b0;
            stall        <= 1'b0;
            wb_valid     <= 1'b0;
            wb_reg       <= '0;
            wb_data      <= '0;
        end else begin
            start_mult   <= 1'b0;
            start_div    <= 1'b0;
            md_interrupt <= 1'b0;
            wb_valid     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state      <= ST_LAUNCH;
                        stall      <= 1'b1;
                        start_div  <= issue_div;
                        start_mult <= !issue_div;
                    end
                end
                ST_LAUNCH: begin
                    if (flush) begin
                        state        <= ST_IDLE;
                        stall        <= 1'b0;
                        md_interrupt <= 1'b1;
                    end else begin
                        state     <= ST_WAIT;
                        firstWait <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    firstWait <= 1'b0;
                    // A ready still high from the previous op must not complete this one.
                    if (flush) begin
                        state        <= ST_IDLE;
                        stall        <= 1'b0;
                        md_interrupt <= 1'b1;
                    end else if (md_ready && !firstWait) begin
                        state    <= ST_WB;
                        wb_valid <= 1'b1;
                        if (md_exception) begin
                            wb_reg  <= REG_W'(STATUS_REG);
                            wb_data <= excData;
                        end else begin
                            wb_reg  <= destQ;
                            wb_data <= md_result;
                        end
                    end
`ifdef MD_TIMEOUT_EN
                    else if (timedOut) begin
                        state        <= ST_WB;
                        md_interrupt <= 1'b1;
                        wb_valid     <= 1'b1;
                        wb_reg       <= REG_W'(STATUS_REG);
                        wb_data      <= excData;
                    end
`endif
                end
                ST_WB: begin
                    // Already committed: a flush here does not cancel the beat.
                    state   <= ST_IDLE;
                    stall   <= 1'b0;
                    wb_reg  <= '0;
                    wb_data <= '0;
                end
            endcase
        end
    end

endmodule
